// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and the controller state encoding.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : mult_pkg

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder, one full-adder cell per bit.
// Used as the per-iteration adder of the multiplier datapath.
module ripple_carry_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] chain;

   assign chain[0] = cin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign sum[gi]       = a[gi] ^ b[gi] ^ chain[gi];
         assign chain[gi + 1] = (a[gi] & b[gi]) | (chain[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign carry = chain[WIDTH];

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock over WIDTH
// cycles, with valid/ready handshakes on both the operand and result sides.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               done_valid,
   input  logic               done_ready
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t               state_reg;
   logic [WIDTH-1:0]     m_reg;
   logic [WIDTH-1:0]     q_reg;
   logic [WIDTH-1:0]     acc_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [2*WIDTH-1:0]   product_reg;
   logic                 start_ready_reg;
   logic                 done_valid_reg;

   logic [WIDTH-1:0]     gated_m;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [2*WIDTH-1:0]   shifted_next;
   logic [WIDTH-1:0]     acc_next;
   logic [WIDTH-1:0]     q_next;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
         assign gated_m[gi] = m_reg[gi] & q_reg[0];
      end
   endgenerate

   ripple_carry_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a     (acc_reg),
      .b     (gated_m),
      .cin   (1'b0),
      .sum   (sum),
      .carry (carry)
   );

   // {C,S,Q} >> 1: the carry-out becomes the new ACC MSB, S[0] moves into Q.
   assign shifted_next = {carry, sum, q_reg[WIDTH-1:1]};
   assign acc_next     = shifted_next[2*WIDTH-1:WIDTH];
   assign q_next       = shifted_next[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         m_reg           <= '0;
         q_reg           <= '0;
         acc_reg         <= '0;
         cnt_reg         <= '0;
         product_reg     <= '0;
         start_ready_reg <= 1'b1;
         done_valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_valid) begin
                  m_reg           <= a;
                  q_reg           <= b;
                  acc_reg         <= '0;
                  cnt_reg         <= '0;
                  state_reg       <= CALC;
                  start_ready_reg <= 1'b0;
               end
            end
            CALC: begin
               acc_reg <= acc_next;
               q_reg   <= q_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg == LAST_CNT) begin
                  product_reg    <= {acc_next, q_next};
                  state_reg      <= DONE;
                  done_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               // A simultaneous start_valid is deliberately not looked at here.
               if (done_ready) begin
                  state_reg       <= IDLE;
                  done_valid_reg  <= 1'b0;
                  start_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg       <= IDLE;
               done_valid_reg  <= 1'b0;
               start_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign start_ready = start_ready_reg;
   assign done_valid  = done_valid_reg;
   assign product     = product_reg;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed plus random check of shift_add_multiplier with a result scoreboard;
// inputs driven and outputs sampled on the falling clock edge.
module tb_shift_add_multiplier;

   localparam int WIDTH = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start_valid = 1'b0;
   logic               done_ready = 1'b0;
   logic [WIDTH-1:0]   a = '0;
   logic [WIDTH-1:0]   b = '0;
   logic               start_ready;
   logic               done_valid;
   logic [2*WIDTH-1:0] product;

   int                 tests = 0;
   int                 fails = 0;
   logic [2*WIDTH-1:0] exp_q[$];
   logic [2*WIDTH-1:0] last_product = '0;
   logic [2*WIDTH-1:0] dropped;
   bit                 got;

   shift_add_multiplier #(
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .product     (product),
      .done_valid  (done_valid),
      .done_ready  (done_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present operands until accepted; returns at the first falling edge after the accept edge.
   task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
      int n = 0;
      while (start_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("start_ready_timeout", 16'd0, 16'd1);
      a           = ia;
      b           = ib;
      start_valid = 1'b1;
      exp_q.push_back(8'(ia) * 8'(ib));
      @(negedge clk);
      start_valid = 1'b0;
      $display("[TB] accept a=%0d b=%0d", ia, ib);
   endtask

   // Wait for done_valid; product must hold its old value while calculating.
   task automatic await_done(input bit check_latency, output bit ok);
      int n = 1;
      logic [2*WIDTH-1:0] exp;
      while (done_valid !== 1'b1 && n < 50) begin
         check("product_hold_calc", 16'(product), 16'(last_product));
         @(negedge clk);
         n++;
      end
      ok = (done_valid === 1'b1);
      if (!ok) begin
         check("done_timeout", 16'd0, 16'd1);
      end else begin
         if (check_latency) check("latency", 16'(n), 16'd5);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check("product", 16'(product), 16'(exp));
         last_product = product;
         $display("[TB] done product=%0d expected=%0d", product, exp);
      end
   endtask

   // Hold backpressure for bp cycles, then hand the result off.
   task automatic drain(input int bp);
      for (int i = 0; i < bp; i++) begin
         check("hold_done_valid", 16'(done_valid), 16'd1);
         check("hold_product", 16'(product), 16'(last_product));
         check("hold_start_ready", 16'(start_ready), 16'd0);
         @(negedge clk);
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check("idle_start_ready", 16'(start_ready), 16'd1);
      check("idle_done_valid", 16'(done_valid), 16'd0);
      check("idle_product", 16'(product), 16'(last_product));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("reset_product", 16'(product), 16'd0);
      check("reset_start_ready", 16'(start_ready), 16'd1);
      check("reset_done_valid", 16'(done_valid), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Maximum operands, with latency
      launch(4'd15, 4'd15);
      await_done(1'b1, got);
      if (got) drain(0);

      launch(4'd9, 4'd7);
      await_done(1'b1, got);
      if (got) drain(0);
      launch(4'd0, 4'd13);
      await_done(1'b1, got);
      if (got) drain(0);
      launch(4'd13, 4'd0);
      await_done(1'b1, got);
      if (got) drain(0);

      // Long backpressure in DONE
      launch(4'd6, 4'd7);
      await_done(1'b1, got);
      if (got) drain(6);

      // start_valid held during CALC and DONE must be ignored
      launch(4'd5, 4'd6);
      a = 4'd3;
      b = 4'd3;
      start_valid = 1'b1;
      await_done(1'b1, got);
      start_valid = 1'b0;
      if (got) drain(1);
      for (int i = 0; i < 6; i++) begin
         check("ignored_no_done", 16'(done_valid), 16'd0);
         check("ignored_product", 16'(product), 16'd30);
         @(negedge clk);
      end

      // done_ready and start_valid together: only return to IDLE
      launch(4'd2, 4'd3);
      await_done(1'b1, got);
      done_ready  = 1'b1;
      start_valid = 1'b1;
      a = 4'd4;
      b = 4'd5;
      @(negedge clk);
      done_ready = 1'b0;
      check("simul_idle_start_ready", 16'(start_ready), 16'd1);
      check("simul_idle_done_valid", 16'(done_valid), 16'd0);
      exp_q.push_back(8'd20);
      @(negedge clk);
      start_valid = 1'b0;
      check("simul_accept_next", 16'(start_ready), 16'd0);
      await_done(1'b1, got);
      if (got) drain(0);

      // Asynchronous reset mid-CALC
      launch(4'd7, 4'd9);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_product", 16'(product), 16'd0);
      check("async_rst_start_ready", 16'(start_ready), 16'd1);
      check("async_rst_done_valid", 16'(done_valid), 16'd0);
      dropped = exp_q.pop_front();
      last_product = '0;
      $display("[TB] reset aborted a=7 b=9 (dropped %0d)", dropped);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", 16'(done_valid), 16'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      launch(4'd11, 4'd12);
      await_done(1'b1, got);
      if (got) drain(1);

      // Random operands with random backpressure
      for (int i = 0; i < 16; i++) begin
         launch(4'($urandom_range(15)), 4'($urandom_range(15)));
         await_done(1'b0, got);
         if (got) drain(int'($urandom_range(3)));
      end

      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_shift_add_multiplier
